register_file_mp: RTL

//   Parametrised successor to the datapath register file: 2 combinational read ports, 2 clocked

---
 rtl/register_file_mp_pkg.sv | 11 +
 rtl/register_file_mp_scoreboard.sv | 36 +++
 rtl/register_file_mp.sv | 77 +++++++
 3 files changed

// File: rtl/register_file_mp_pkg.sv
// register_file_mp_pkg: shared defaults and index helpers for the multi-port register file.
package register_file_mp_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int REG_ZERO   = 0;

  // True when idx names a real register that may be written, forwarded or marked busy
  function automatic logic idx_live(input int idx, input int num_regs, input logic zero_reg);
    return idx < num_regs && !(zero_reg && idx == REG_ZERO);
  endfunction
endpackage

// File: rtl/register_file_mp_scoreboard.sv
// register_file_mp_scoreboard: per-register pending-write bits; issue sets, write clears, set wins.
module register_file_mp_scoreboard
  import register_file_mp_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_REGS = 2 ** ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                issue_valid_i,
  input  logic [ADDR_W-1:0]   issue_reg_i,
  input  logic                wr_a_i,
  input  logic [ADDR_W-1:0]   wr_a_reg_i,
  input  logic                wr_b_i,
  input  logic [ADDR_W-1:0]   wr_b_reg_i,
  output logic [NUM_REGS-1:0] busy_o
);
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic set_ok;

  assign set_ok = issue_valid_i && idx_live(int'(issue_reg_i), NUM_REGS, ZERO_REG != 0);

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++)
      busy_d[i] = (set_ok && issue_reg_i == ADDR_W'(i)) ? 1'b1 :
                  ((wr_a_i && wr_a_reg_i == ADDR_W'(i)) || (wr_b_i && wr_b_reg_i == ADDR_W'(i))) ? 1'b0 :
                  busy_q[i];
  end

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) busy_q <= '0;
    else         busy_q <= busy_d;

  assign busy_o = busy_q;
endmodule

// File: rtl/register_file_mp.sv
// register_file_mp: 2-read/2-write register file with optional write-through bypass
// and a busy scoreboard for hazard stalls.
module register_file_mp
  import register_file_mp_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_REGS = 2 ** ADDR_W,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [ADDR_W-1:0] ReadRegister1,
  input  logic [ADDR_W-1:0] ReadRegister2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic              ReadBusy1,
  output logic              ReadBusy2,
  input  logic              RegWriteA,
  input  logic [ADDR_W-1:0] WriteRegisterA,
  input  logic [DATA_W-1:0] WriteDataA,
  input  logic              RegWriteB,
  input  logic [ADDR_W-1:0] WriteRegisterB,
  input  logic [DATA_W-1:0] WriteDataB,
  input  logic              IssueValid,
  input  logic [ADDR_W-1:0] IssueRegister
);
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic                wa_ok, wb_ok;
  logic [ADDR_W-1:0]   ra [2];
  logic [DATA_W-1:0]   rd [2];
  logic [1:0]          rok, hit_a, hit_b, rb;

  assign wa_ok = RegWriteA && idx_live(int'(WriteRegisterA), NUM_REGS, ZERO_REG != 0);
  assign wb_ok = RegWriteB && idx_live(int'(WriteRegisterB), NUM_REGS, ZERO_REG != 0);

  // A applied last so it overrides B on a shared index
  always_comb begin
    regs_d = regs_q;
    if (wb_ok) regs_d[WriteRegisterB] = WriteDataB;
    if (wa_ok) regs_d[WriteRegisterA] = WriteDataA;
  end

  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) regs_q <= '{default: '0};
    else        regs_q <= regs_d;

  register_file_mp_scoreboard #(
    .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .ZERO_REG(ZERO_REG)
  ) u_sb (
    .clk_i(Clk), .rst_ni(Rst_n),
    .issue_valid_i(IssueValid), .issue_reg_i(IssueRegister),
    .wr_a_i(wa_ok), .wr_a_reg_i(WriteRegisterA),
    .wr_b_i(wb_ok), .wr_b_reg_i(WriteRegisterB),
    .busy_o(busy)
  );

  assign ra[0] = ReadRegister1;
  assign ra[1] = ReadRegister2;

  for (genvar p = 0; p < 2; p++) begin : g_rd
    assign rok[p]   = idx_live(int'(ra[p]), NUM_REGS, ZERO_REG != 0);
    assign hit_a[p] = BYPASS != 0 && wa_ok && WriteRegisterA == ra[p];
    assign hit_b[p] = BYPASS != 0 && wb_ok && WriteRegisterB == ra[p];
    assign rd[p]    = !rok[p] ? '0 : hit_a[p] ? WriteDataA : hit_b[p] ? WriteDataB : regs_q[ra[p]];
    // forwarded data already satisfies the consumer, so hide the pending bit
    assign rb[p]    = rok[p] && busy[ra[p]] && !(hit_a[p] || hit_b[p]);
  end

  assign ReadData1 = rd[0];
  assign ReadData2 = rd[1];
  assign ReadBusy1 = rb[0];
  assign ReadBusy2 = rb[1];
endmodule
